instruction_prefetch: RTL and testbench

Parametrised successor to the CPU's single-shot instruction fetch: issues sequential word reads on the system bus, keeps up to DEPTH reads outstanding or buffered, and presents fetched instructions with their PC to decode over a valid/ready handshake. Supports redirects for branches and traps: it flushes buffered words, silently discards in-flight responses, and restarts at the new PC. Sits between the system bus master port and decode inside `cpu`.

---
 rtl/prefetch_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instruction_prefetch.sv | 129 ++++++++++++
 tb/tb_instruction_prefetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package prefetch_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } prefetch_state_t;

    function automatic int unsigned ctr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, data} entries; flush beats push and pop.
module fetch_fifo
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count < CW'(DEPTH)) || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Sequential instruction prefetcher: credit-limited bus reads, in-order response
// buffering, and redirect with discard of in-flight responses.
module instruction_prefetch
    import prefetch_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  system_bus_ready,
    output logic [ADDR_WIDTH-1:0] system_bus_addr,
    output logic [3:0]            system_bus_byte_enable,
    output logic                  system_bus_read_req,
    input  logic [DATA_WIDTH-1:0] system_bus_read_data,
    input  logic                  system_bus_read_data_valid,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    localparam int unsigned CW = ctr_width(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [ADDR_WIDTH-1:0] redirect_base;
    logic [CW-1:0]         pending;
    logic [CW-1:0]         drop;
    logic [CW-1:0]         count;
    logic [CW-1:0]         pending_after_resp;
    logic [CW-1:0]         drop_next;
    logic [CW:0]           in_use;
    prefetch_state_t       state;
    logic                  accept;
    logic                  discard;
    logic                  push;
    logic                  pop;
    entry_t                push_entry;
    entry_t                head;

    always_comb begin
        in_use              = {1'b0, count} + {1'b0, pending};
        system_bus_read_req = enable && !redirect && (in_use < (CW+1)'(DEPTH));
        accept              = system_bus_read_req && system_bus_ready;
        redirect_base       = redirect_pc & ~ADDR_WIDTH'(WORD_BYTES - 1);

        discard             = (state == FLUSH);
        push                = system_bus_read_data_valid && !discard;
        push_entry.pc       = resp_pc;
        push_entry.data     = system_bus_read_data;
        pop                 = instr_valid && instr_ready;

        pending_after_resp  = pending - CW'(system_bus_read_data_valid);
        // Every read still outstanding after this cycle's response is stale once we redirect.
        if (redirect) begin
            drop_next = pending_after_resp;
        end else if (system_bus_read_data_valid && discard) begin
            drop_next = drop - CW'(1);
        end else begin
            drop_next = drop;
        end
    end

    // FLUSH outranks IDLE so a flush still in progress is tracked while fetch is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            pending  <= '0;
            drop     <= '0;
            state    <= IDLE;
        end else begin
            pending <= pending_after_resp + CW'(accept);
            drop    <= drop_next;
            if (drop_next != '0) begin
                state <= FLUSH;
            end else if (enable) begin
                state <= FETCH;
            end else begin
                state <= IDLE;
            end
            if (redirect) begin
                fetch_pc <= redirect_base;
                resp_pc  <= redirect_base;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + ADDR_WIDTH'(WORD_BYTES);
                end
                if (push) begin
                    resp_pc <= resp_pc + ADDR_WIDTH'(WORD_BYTES);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect),
        .head       (head),
        .count      (count)
    );

    always_comb begin
        system_bus_addr        = fetch_pc;
        system_bus_byte_enable = 4'hf;
        instr_valid            = (count != '0);
        instr_data             = head.data;
        instr_pc               = head.pc;
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Randomized bench for instruction_prefetch against a queue-based model of the bus and decode stream.
module tb_instruction_prefetch;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        system_bus_ready;
    logic [31:0] system_bus_addr;
    logic [3:0]  system_bus_byte_enable;
    logic        system_bus_read_req;
    logic [31:0] system_bus_read_data;
    logic        system_bus_read_data_valid;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    instruction_prefetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .enable                     (enable),
        .redirect                   (redirect),
        .redirect_pc                (redirect_pc),
        .system_bus_ready           (system_bus_ready),
        .system_bus_addr            (system_bus_addr),
        .system_bus_byte_enable     (system_bus_byte_enable),
        .system_bus_read_req        (system_bus_read_req),
        .system_bus_read_data       (system_bus_read_data),
        .system_bus_read_data_valid (system_bus_read_data_valid),
        .instr_valid                (instr_valid),
        .instr_ready                (instr_ready),
        .instr_data                 (instr_data),
        .instr_pc                   (instr_pc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reads accepted by the bus, oldest first; live=0 once a redirect makes them stale.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } rd_t;

    rd_t         bq[$];
    logic [63:0] fq[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          lat_lo, lat_hi;

    int          obs_acc, obs_req, obs_valid, obs_pop;
    bit          seen_req, seen_valid;
    int          first_req_cyc, first_valid_cyc;
    logic [31:0] first_valid_pc;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, ~a[31:16]};
    endfunction

    task automatic clear_obs();
        obs_acc    = 0;
        obs_req    = 0;
        obs_valid  = 0;
        obs_pop    = 0;
        seen_req   = 1'b0;
        seen_valid = 1'b0;
    endtask

    task automatic step(input bit en, input bit bus_rdy, input bit dec_rdy,
                        input bit redir, input logic [31:0] rpc);
        bit  resp, exp_req, acc, pop;
        rd_t r;
        @(negedge clk);
        enable           = en;
        system_bus_ready = bus_rdy;
        instr_ready      = dec_rdy;
        redirect         = redir;
        redirect_pc      = redir ? rpc : $urandom();
        resp             = (bq.size() > 0) && (bq[0].due <= cyc);
        system_bus_read_data_valid = resp;
        system_bus_read_data       = resp ? word_at(bq[0].addr) : $urandom();
        #1;
        exp_req = en && !redir && ((fq.size() + bq.size()) < DEPTH);
        check_eq("read_req", system_bus_read_req, exp_req);
        if (exp_req) check_eq("bus_addr", system_bus_addr, m_fetch_pc);
        check_eq("byte_enable", system_bus_byte_enable, 4'hf);
        check_eq("instr_valid", instr_valid, fq.size() != 0);
        if (fq.size() != 0) begin
            check_eq("instr_pc", instr_pc, fq[0][63:32]);
            check_eq("instr_data", instr_data, fq[0][31:0]);
        end

        if (system_bus_read_req) begin
            obs_req++;
            if (!seen_req) begin
                seen_req      = 1'b1;
                first_req_cyc = cyc;
            end
            if (bus_rdy) obs_acc++;
        end
        if (instr_valid) begin
            obs_valid++;
            if (dec_rdy && !redir) obs_pop++;
            if (!seen_valid) begin
                seen_valid      = 1'b1;
                first_valid_cyc = cyc;
                first_valid_pc  = instr_pc;
            end
        end

        acc = exp_req && bus_rdy;
        pop = !redir && dec_rdy && (fq.size() != 0);
        if (pop) void'(fq.pop_front());
        if (resp) begin
            r = bq.pop_front();
            if (r.live && !redir) fq.push_back({r.addr, word_at(r.addr)});
        end
        if (redir) begin
            fq.delete();
            foreach (bq[i]) bq[i].live = 1'b0;
            m_fetch_pc = rpc & 32'hFFFF_FFFC;
        end
        if (acc) begin
            bq.push_back('{addr: m_fetch_pc, due: cyc + $urandom_range(lat_hi, lat_lo), live: 1'b1});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic drain();
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        reset_n = 1'b1;
        enable = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        system_bus_ready = 1'b0;
        system_bus_read_data = '0;
        system_bus_read_data_valid = 1'b0;
        instr_ready = 1'b0;
        m_fetch_pc = 32'h0;
        cyc = 0;
        lat_lo = 2;
        lat_hi = 2;
        first_req_cyc = 0;
        first_valid_cyc = 0;
        first_valid_pc = '0;
        clear_obs();

        #2 reset_n = 1'b0;
        #10;
        check_eq("rst_read_req", system_bus_read_req, 1'b0);
        check_eq("rst_addr", system_bus_addr, 32'h0);
        check_eq("rst_byte_enable", system_bus_byte_enable, 4'hf);
        check_eq("rst_instr_valid", instr_valid, 1'b0);
        check_eq("rst_instr_data", instr_data, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming with fixed 2-cycle bus latency and decode always ready.
        clear_obs();
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("first_latency", first_valid_cyc - first_req_cyc, 3);
        check_eq("first_pc", first_valid_pc, 32'h0);
        check_eq("stream_valid_cycles", obs_valid, 9);

        // Decode stalled: credits run out after DEPTH accepted reads.
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        clear_obs();
        repeat (14) step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("stall_accepts", obs_acc, DEPTH);
        check_eq("stall_req_off", system_bus_read_req, 1'b0);
        clear_obs();
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("stall_release_first_pc", first_valid_pc, 32'h200);

        // Three reads in flight, then redirect to an unaligned PC.
        drain();
        lat_lo = 5;
        lat_hi = 5;
        for (int i = 0; i < 20 && bq.size() != 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("setup_three_outstanding", bq.size(), 3);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h103);
        clear_obs();
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("redir_addr", system_bus_addr, 32'h100);
        check_eq("redir_no_valid", instr_valid, 1'b0);
        repeat (14) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("redir_first_pc", first_valid_pc, 32'h100);

        // Redirect colliding with a live response and a pop.
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 30 && !((fq.size() > 0) && (bq.size() > 0) && (bq[0].due <= cyc)); i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("setup_collision", (fq.size() > 0) && (bq.size() > 0) && (bq[0].due <= cyc), 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h401);
        clear_obs();
        repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("collision_first_pc", first_valid_pc, 32'h400);

        // Address wrap at the top of the space.
        drain();
        lat_lo = 2;
        lat_hi = 2;
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr_top", system_bus_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr_zero", system_bus_addr, 32'h0);
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Disable with two reads outstanding.
        drain();
        lat_lo = 4;
        lat_hi = 4;
        for (int i = 0; i < 20 && bq.size() != 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("setup_two_outstanding", bq.size(), 2);
        clear_obs();
        repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("disabled_no_req", obs_req, 0);
        check_eq("disabled_delivered", obs_pop, 2);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check_eq("reenable_req", system_bus_read_req, 1'b1);

        // Randomized traffic.
        lat_lo = 1;
        lat_hi = 6;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0, rpc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
